multi_ch_accum: RTL and testbench

//  Multi-channel accumulator. Successor to the single-channel, fixed-width 4b->8b accumulator.

---
 rtl/accum_pkg.sv | 39 +++
 rtl/accum_lane.sv | 75 +++++++
 rtl/multi_ch_accum.sv | 138 +++++++++++++
 tb/tb_multi_ch_accum.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and the saturating/wrapping adder for the multi-channel accumulator.
// Latency: none (types and a combinational helper function only).
// Backpressure: not applicable.
package accum_pkg;

    // Widest accumulator the helper function supports.
    localparam int ACC_MAX_W = 32;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_e;

    // Returns {carry, result}. The carry is set when sum+val exceeds 2**sum_w-1.
    // On a carry the result clamps to 2**sum_w-1 (sat=1) or wraps modulo 2**sum_w (sat=0).
    function automatic logic [ACC_MAX_W:0] sat_add(
        input logic [ACC_MAX_W-1:0] sum,
        input logic [ACC_MAX_W-1:0] val,
        input int unsigned          sum_w,
        input logic                 sat
    );
        logic [ACC_MAX_W:0] full;
        logic [ACC_MAX_W:0] lim;
        logic               carry;
        lim   = ({{ACC_MAX_W{1'b0}}, 1'b1} << sum_w) - 1'b1;
        full  = {1'b0, sum} + {1'b0, val};
        carry = (full > lim);
        if (carry) begin
            full = sat ? lim : (full & lim);
        end
        return {carry, full[ACC_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/accum_lane.sv
// One channel's running sum, sample count and sticky overflow flag.
// Latency: state updates on the edge after an accepted beat; res_* are combinational.
// Backpressure: none locally; the top only asserts upd for accepted beats.
//
// Ports: clk/rst; upd marks an accepted beat for this channel, term closes the run,
// value is the beat value. res_sum/res_cnt/res_ovf are the totals including the
// current beat, used by the top to load the result register on a term beat.
module accum_lane
    import accum_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int SUM_W    = 8,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic              term,
    input  logic [DATA_W-1:0] value,
    output logic [SUM_W-1:0]  res_sum,
    output logic [CNT_W-1:0]  res_cnt,
    output logic              res_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    ch_state_e          ch_state;
    logic [SUM_W-1:0]   base_sum;
    logic [ACC_MAX_W:0] add_r;

    // A channel with no beats yet starts from a clean zero sum.
    assign ch_state = (cnt_q == '0) ? CH_IDLE : CH_ACTIVE;
    assign base_sum = (ch_state == CH_IDLE) ? '0 : sum_q;

    always_comb begin
        add_r   = sat_add(ACC_MAX_W'(base_sum), ACC_MAX_W'(value), SUM_W, SATURATE);
        res_sum = add_r[SUM_W-1:0];
        res_ovf = ovf_q | add_r[ACC_MAX_W];
        // Count sticks at its maximum instead of wrapping.
        res_cnt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

        sum_d = sum_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (upd) begin
            if (term) begin
                sum_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else begin
                sum_d = res_sum;
                cnt_d = res_cnt;
                ovf_d = res_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/multi_ch_accum.sv
// Multi-channel accumulator: per-channel sums, closed by a term beat into a held result.
// Latency: result valid exactly 1 cycle after the accepted term beat; O_ERR 1 cycle after a bad beat.
// Backpressure: O_READY = !O_VALID || I_READY (combinational, no skid); result held until accepted.
//
// Ports: input beat I_VALID/O_READY with I_CH, I_VALUE, I_TERM; result O_VALID/I_READY with
// O_CH, O_SUM, O_COUNT, O_OVF; O_ERR pulses for an accepted beat on a non-existent channel.
module multi_ch_accum
    import accum_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 4,
    parameter int SUM_W    = 8,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      I_VALID,
    output logic                      O_READY,
    input  logic [$clog2(NUM_CH)-1:0] I_CH,
    input  logic [DATA_W-1:0]         I_VALUE,
    input  logic                      I_TERM,
    output logic                      O_VALID,
    input  logic                      I_READY,
    output logic [$clog2(NUM_CH)-1:0] O_CH,
    output logic [SUM_W-1:0]          O_SUM,
    output logic [CNT_W-1:0]          O_COUNT,
    output logic                      O_OVF,
    output logic                      O_ERR
);

    localparam int CH_W = $clog2(NUM_CH);

    out_state_e        out_state_q, out_state_d;
    logic [CH_W-1:0]   o_ch_q, o_ch_d;
    logic [SUM_W-1:0]  o_sum_q, o_sum_d;
    logic [CNT_W-1:0]  o_cnt_q, o_cnt_d;
    logic              o_ovf_q, o_ovf_d;
    logic              o_err_q, o_err_d;

    logic              beat_acc;
    logic              ch_ok;
    logic              term_fire;
    logic [NUM_CH-1:0] lane_upd;
    logic [SUM_W-1:0]  lane_sum [NUM_CH];
    logic [CNT_W-1:0]  lane_cnt [NUM_CH];
    logic              lane_ovf [NUM_CH];
    logic [SUM_W-1:0]  sel_sum;
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_ovf;

    assign O_VALID   = (out_state_q == OUT_FULL);
    assign O_READY   = (out_state_q == OUT_EMPTY) || I_READY;
    assign beat_acc  = I_VALID && O_READY;
    assign ch_ok     = (32'(I_CH) < NUM_CH);
    assign term_fire = beat_acc && ch_ok && I_TERM;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            assign lane_upd[g] = beat_acc && ch_ok && (I_CH == CH_W'(g));
            accum_lane #(
                .DATA_W   (DATA_W),
                .SUM_W    (SUM_W),
                .CNT_W    (CNT_W),
                .SATURATE (SATURATE)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .upd     (lane_upd[g]),
                .term    (I_TERM),
                .value   (I_VALUE),
                .res_sum (lane_sum[g]),
                .res_cnt (lane_cnt[g]),
                .res_ovf (lane_ovf[g])
            );
        end
    endgenerate

    // Select the addressed lane's totals; a bad index selects nothing (term_fire is low then).
    always_comb begin
        sel_sum = '0;
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (I_CH == CH_W'(i)) begin
                sel_sum = lane_sum[i];
                sel_cnt = lane_cnt[i];
                sel_ovf = lane_ovf[i];
            end
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        o_ch_d      = o_ch_q;
        o_sum_d     = o_sum_q;
        o_cnt_d     = o_cnt_q;
        o_ovf_d     = o_ovf_q;
        o_err_d     = beat_acc && !ch_ok;
        // A term beat can only be accepted when the slot is empty or being drained,
        // so loading here gives back-to-back results with no bubble.
        if (term_fire) begin
            out_state_d = OUT_FULL;
            o_ch_d      = I_CH;
            o_sum_d     = sel_sum;
            o_cnt_d     = sel_cnt;
            o_ovf_d     = sel_ovf;
        end else if ((out_state_q == OUT_FULL) && I_READY) begin
            out_state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q <= OUT_EMPTY;
            o_ch_q      <= '0;
            o_sum_q     <= '0;
            o_cnt_q     <= '0;
            o_ovf_q     <= 1'b0;
            o_err_q     <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            o_ch_q      <= o_ch_d;
            o_sum_q     <= o_sum_d;
            o_cnt_q     <= o_cnt_d;
            o_ovf_q     <= o_ovf_d;
            o_err_q     <= o_err_d;
        end
    end

    assign O_CH    = o_ch_q;
    assign O_SUM   = o_sum_q;
    assign O_COUNT = o_cnt_q;
    assign O_OVF   = o_ovf_q;
    assign O_ERR   = o_err_q;

endmodule

// File: tb/tb_multi_ch_accum.sv
// Bench for multi_ch_accum: two instances share one stimulus stream.
// dut 0: NUM_CH=4, SATURATE=1.  dut 1: NUM_CH=3, SATURATE=0 (index 3 is a bad channel).
// Each is checked against a per-instance reference model every cycle.
module tb_multi_ch_accum;

    localparam int MAXS = 255;
    localparam int MAXC = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       I_VALID = 1'b0;
    logic [1:0] I_CH = '0;
    logic [3:0] I_VALUE = '0;
    logic       I_TERM = 1'b0;
    logic       I_READY = 1'b0;

    logic       a_ready, a_valid, a_ovf, a_err;
    logic [1:0] a_ch;
    logic [7:0] a_sum, a_cnt;
    logic       b_ready, b_valid, b_ovf, b_err;
    logic [1:0] b_ch;
    logic [7:0] b_sum, b_cnt;

    always #5 clk = ~clk;

    multi_ch_accum #(.NUM_CH(4), .DATA_W(4), .SUM_W(8), .CNT_W(8), .SATURATE(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .I_VALID(I_VALID), .O_READY(a_ready), .I_CH(I_CH),
        .I_VALUE(I_VALUE), .I_TERM(I_TERM), .O_VALID(a_valid), .I_READY(I_READY),
        .O_CH(a_ch), .O_SUM(a_sum), .O_COUNT(a_cnt), .O_OVF(a_ovf), .O_ERR(a_err)
    );

    multi_ch_accum #(.NUM_CH(3), .DATA_W(4), .SUM_W(8), .CNT_W(8), .SATURATE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .I_VALID(I_VALID), .O_READY(b_ready), .I_CH(I_CH),
        .I_VALUE(I_VALUE), .I_TERM(I_TERM), .O_VALID(b_valid), .I_READY(I_READY),
        .O_CH(b_ch), .O_SUM(b_sum), .O_COUNT(b_cnt), .O_OVF(b_ovf), .O_ERR(b_err)
    );

    // DUT outputs gathered per instance
    int d_rdy[2], d_vld[2], d_ch[2], d_sum[2], d_cnt[2], d_ovf[2], d_err[2];
    always_comb begin
        d_rdy[0] = int'(a_ready); d_vld[0] = int'(a_valid); d_ch[0] = int'(a_ch);
        d_sum[0] = int'(a_sum);   d_cnt[0] = int'(a_cnt);   d_ovf[0] = int'(a_ovf);
        d_err[0] = int'(a_err);
        d_rdy[1] = int'(b_ready); d_vld[1] = int'(b_valid); d_ch[1] = int'(b_ch);
        d_sum[1] = int'(b_sum);   d_cnt[1] = int'(b_cnt);   d_ovf[1] = int'(b_ovf);
        d_err[1] = int'(b_err);
    end

    // Reference model: plain integer arithmetic on the behavioural rules.
    int nch[2] = '{4, 3};
    bit sat[2] = '{1'b1, 1'b0};
    int m_sum[2][4];
    int m_cnt[2][4];
    int m_ovf[2][4];
    int m_vld[2], m_och[2], m_osum[2], m_ocnt[2], m_oovf[2], m_err[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input int k, input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                m_sum[k][c] = 0; m_cnt[k][c] = 0; m_ovf[k][c] = 0;
            end
            m_vld[k] = 0; m_och[k] = 0; m_osum[k] = 0; m_ocnt[k] = 0; m_oovf[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk(k, "o_valid", d_vld[k], m_vld[k]);
            chk(k, "o_err", d_err[k], m_err[k]);
            if (m_vld[k] != 0) begin
                chk(k, "o_ch", d_ch[k], m_och[k]);
                chk(k, "o_sum", d_sum[k], m_osum[k]);
                chk(k, "o_count", d_cnt[k], m_ocnt[k]);
                chk(k, "o_ovf", d_ovf[k], m_oovf[k]);
            end
        end
    endtask

    // One clock cycle: drive on the falling edge, check O_READY, then check outputs after the edge.
    task automatic step(input bit v, input int ch, input int val, input bit term, input bit rdy);
        bit acc[2];
        int s, c;
        @(negedge clk);
        I_VALID = v; I_CH = ch[1:0]; I_VALUE = val[3:0]; I_TERM = term; I_READY = rdy;
        #1;
        for (int k = 0; k < 2; k++) begin
            acc[k] = v && ((m_vld[k] == 0) || rdy);
            chk(k, "o_ready", d_rdy[k], int'((m_vld[k] == 0) || rdy));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0;
            if ((m_vld[k] != 0) && rdy) m_vld[k] = 0;
            if (acc[k]) begin
                if (ch >= nch[k]) begin
                    m_err[k] = 1;
                end else begin
                    s = m_sum[k][ch] + val;
                    c = (m_cnt[k][ch] + 1 > MAXC) ? MAXC : m_cnt[k][ch] + 1;
                    if (s > MAXS) begin
                        m_ovf[k][ch] = 1;
                        s = sat[k] ? MAXS : s % (MAXS + 1);
                    end
                    if (term) begin
                        m_vld[k] = 1; m_och[k] = ch; m_osum[k] = s; m_ocnt[k] = c;
                        m_oovf[k] = m_ovf[k][ch];
                        m_sum[k][ch] = 0; m_cnt[k][ch] = 0; m_ovf[k][ch] = 0;
                    end else begin
                        m_sum[k][ch] = s; m_cnt[k][ch] = c;
                    end
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; I_VALID = 1'b0; I_TERM = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_valid", d_vld[k], 0);
            chk(k, "rst_ch", d_ch[k], 0);
            chk(k, "rst_sum", d_sum[k], 0);
            chk(k, "rst_count", d_cnt[k], 0);
            chk(k, "rst_ovf", d_ovf[k], 0);
            chk(k, "rst_err", d_err[k], 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v; int ch; int val; bit term; bit rdy;
        bit e_vld; int e_ch; int e_sum; int e_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // T1 basic, then T2 interleave (expectations for dut 0)
        tbl[0] = '{1, 0, 4, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 3, 0, 1, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 2, 0, 1, 0, 0, 0, 0};
        tbl[3] = '{1, 0, 1, 1, 1, 1, 0, 10, 4};
        tbl[4] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 5, 0, 1, 0, 0, 0, 0};
        tbl[6] = '{1, 2, 7, 0, 1, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 6, 1, 1, 1, 1, 11, 2};
        tbl[8] = '{1, 2, 1, 1, 1, 1, 2, 8, 2};
        tbl[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].ch, tbl[i].val, tbl[i].term, tbl[i].rdy);
            chk(0, "tbl_valid", d_vld[0], int'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk(0, "tbl_ch", d_ch[0], tbl[i].e_ch);
                chk(0, "tbl_sum", d_sum[0], tbl[i].e_sum);
                chk(0, "tbl_count", d_cnt[0], tbl[i].e_cnt);
                chk(0, "tbl_ovf", d_ovf[0], 0);
            end
        end

        // T3 backpressure: hold a result, stall a beat, then release together with a term beat
        step(1, 1, 3, 1, 0);
        step(1, 0, 5, 0, 0);
        chk(0, "t3_ready_stalled", d_rdy[0], 0);
        chk(0, "t3_hold_sum", d_sum[0], 3);
        chk(0, "t3_hold_ch", d_ch[0], 1);
        step(1, 0, 5, 1, 1);
        chk(0, "t3_next_valid", d_vld[0], 1);
        chk(0, "t3_next_sum", d_sum[0], 5);
        chk(0, "t3_next_count", d_cnt[0], 1);
        step(0, 0, 0, 0, 1);

        // T4 overflow on ch3 (dut 0 saturates; ch3 is bad on dut 1), then ch2 for the wrapping dut
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 20; i++) step(1, 3 - r, 15, 0, 1);
            step(1, 3 - r, 0, 1, 1);
            chk(0, "t4_sat_sum", d_sum[0], 255);
            chk(0, "t4_sat_count", d_cnt[0], 21);
            chk(0, "t4_sat_ovf", d_ovf[0], 1);
            if (r == 1) begin
                chk(1, "t4_wrap_sum", d_sum[1], 44);
                chk(1, "t4_wrap_ovf", d_ovf[1], 1);
            end
        end
        step(0, 0, 0, 0, 1);

        // Count saturation boundary
        for (int i = 0; i < 300; i++) step(1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1);
        chk(0, "cnt_sat_count", d_cnt[0], 255);
        chk(1, "cnt_sat_count", d_cnt[1], 255);
        chk(1, "cnt_wrap_sum", d_sum[1], 301 % 256);

        // T5 reset mid-run with a held result present
        step(1, 0, 9, 0, 1);
        step(1, 1, 1, 1, 0);
        do_reset();
        step(1, 0, 2, 1, 1);
        chk(0, "t5_sum", d_sum[0], 2);
        chk(0, "t5_count", d_cnt[0], 1);
        step(0, 0, 0, 0, 1);

        // T6 bad channel term on the 3-channel dut
        step(1, 2, 4, 0, 1);
        step(1, 3, 5, 1, 1);
        chk(1, "t6_err", d_err[1], 1);
        chk(1, "t6_no_valid", d_vld[1], 0);
        step(1, 2, 1, 1, 1);
        chk(1, "t6_err_clear", d_err[1], 0);
        chk(1, "t6_sum_kept", d_sum[1], 5);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
